add_stream_core: RTL and testbench

Pipelined streaming adder: the DUT stage between the add_in and add_out agents of the add_ben bench. It accepts operand pairs over a valid/ready input port, which the add_in agent drives. It computes an unsigned sum with carry through a two-stage pipeline and buffers results in an output FIFO. Results leave over a valid/ready output port, which the add_out agent monitors and back-pressures.

---
 rtl/add_stream_pkg.sv | 13 +
 rtl/add_stream_fifo.sv | 55 +++++
 rtl/add_stream_core.sv | 85 ++++++++
 tb/tb_add_stream_core.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/add_stream_pkg.sv
// Shared constants, types and helpers for the streaming adder slice.
package add_stream_pkg;

  localparam int ADD_DATA_WIDTH = 8;

  typedef logic [ADD_DATA_WIDTH:0] add_sum_t;

  // One extra bit so the count can hold DEPTH itself, not just DEPTH-1.
  function automatic int fifo_count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/add_stream_fifo.sv
// Synchronous FIFO holding finished sums until the consumer takes them.
module add_stream_fifo
  import add_stream_pkg::*;
#(
  parameter int WIDTH = ADD_DATA_WIDTH + 1,
  parameter int DEPTH = 4
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               push,
  input  logic                               pop,
  input  logic [WIDTH-1:0]                   din,
  output logic [WIDTH-1:0]                   head,
  output logic                               full,
  output logic                               empty,
  output logic [fifo_count_width(DEPTH)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = fifo_count_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/add_stream_core.sv
// Two-stage unsigned adder with a credit-gated input and a buffered output.
module add_stream_core
  import add_stream_pkg::*;
#(
  parameter int DATA_WIDTH = ADD_DATA_WIDTH,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH:0]   out_sum,
  output logic [CNT_WIDTH-1:0]  txn_count
);

  localparam int CW = fifo_count_width(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] s1_a;
  logic [DATA_WIDTH-1:0] s1_b;
  logic                  s1_valid;
  logic [DATA_WIDTH:0]   s2_sum;
  logic                  s2_valid;
  logic                  in_xfer;
  logic                  out_xfer;
  logic                  fifo_empty;
  logic                  fifo_full_unused;
  logic [CW-1:0]         fifo_count;
  logic [CW-1:0]         count_next;
  logic [CW:0]           occupancy_next;

  assign in_xfer   = in_valid & in_ready;
  assign out_valid = ~fifo_empty;
  assign out_xfer  = out_valid & out_ready;

  // Every operand in flight already owns a FIFO slot, so stage 2 never stalls.
  assign count_next     = fifo_count + CW'(s2_valid) - CW'(out_xfer);
  assign occupancy_next = {1'b0, count_next} + (CW+1)'(s1_valid) + (CW+1)'(in_xfer);

  add_stream_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (s2_valid),
    .pop   (out_ready),
    .din   (s2_sum),
    .head  (out_sum),
    .full  (fifo_full_unused),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_a      <= '0;
      s1_b      <= '0;
      s1_valid  <= 1'b0;
      s2_sum    <= '0;
      s2_valid  <= 1'b0;
      in_ready  <= 1'b0;
      txn_count <= '0;
    end else begin
      s1_valid <= in_xfer;
      if (in_xfer) begin
        s1_a <= in_a;
        s1_b <= in_b;
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_sum <= {1'b0, s1_a} + {1'b0, s1_b};
      end
      in_ready <= (occupancy_next < (CW+1)'(FIFO_DEPTH));
      if (out_xfer) begin
        txn_count <= txn_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_add_stream_core.sv
// Scoreboard bench for add_stream_core; a 4-bit-counter twin shares all inputs.
module tb_add_stream_core;
  import add_stream_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        out_valid;
  logic        out_ready;
  logic [8:0]  out_sum;
  logic [15:0] txn_count;
  logic        in_ready_unused;
  logic        out_valid_unused;
  logic [8:0]  out_sum_unused;
  logic [3:0]  txn_count_w;

  int checks_total  = 0;
  int checks_passed = 0;
  int pop_count     = 0;
  int last_pop_cyc  = 0;
  int cyc           = 0;
  add_sum_t exp_q[$];

  add_stream_core #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .CNT_WIDTH(16)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .txn_count(txn_count)
  );

  add_stream_core #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .CNT_WIDTH(4)) dut_wrap (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_unused),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid_unused), .out_ready(out_ready),
    .out_sum(out_sum_unused), .txn_count(txn_count_w)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Offers one pair for up to max_wait cycles; the expected sum is queued only on acceptance.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input add_sum_t exp_sum,
                               input int max_wait, output bit accepted, output int acc_cyc);
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    accepted = 1'b0;
    acc_cyc  = -1;
    for (int i = 0; i < max_wait && !accepted; i++) begin
      @(negedge clock);
      if (in_ready) begin
        accepted = 1'b1;
        acc_cyc  = cyc;
        exp_q.push_back(exp_sum);
      end
      @(posedge clock);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic waitPops(input int target, input int budget);
    for (int i = 0; i < budget && pop_count < target; i++) begin
      @(posedge clock);
      #2;
    end
    checkOutput("pop_count", 32'(pop_count), 32'(target));
  endtask

  task automatic doReset();
    reset    = 1'b1;
    in_valid = 1'b0;
    exp_q.delete();
    pop_count = 0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock);
    #1;
  endtask

  // Monitor: every output transfer is matched against the head of the scoreboard.
  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks_total++;
        $display("[TB] FAIL unexpected_out: got 0x%0h, expected no output", out_sum);
      end else begin
        checkOutput("out_sum", 32'(out_sum), 32'(exp_q.pop_front()));
      end
      pop_count++;
      last_pop_cyc = cyc;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation did not complete");
  end

  initial begin
    bit          acc;
    int          acc_cyc;
    int          acc_total;
    int          first_cyc;
    logic [7:0]  ra;
    logic [7:0]  rb;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_sum", 32'(out_sum), 32'd0);
    checkOutput("rst_txn_count", 32'(txn_count), 32'd0);
    reset = 1'b0;
    @(posedge clock);
    #1;
    checkOutput("in_ready_after_rst", 32'(in_ready), 32'd1);

    // Single transfer and latency
    out_ready = 1'b1;
    applyStimulus(8'h12, 8'h34, 9'h046, 5, acc, acc_cyc);
    checkOutput("accept_single", 32'(acc), 32'd1);
    waitPops(1, 10);
    checkOutput("latency", 32'(last_pop_cyc - acc_cyc), 32'd3);
    checkOutput("txn_single", 32'(txn_count), 32'd1);

    // Carry out of the MSB
    applyStimulus(8'hFF, 8'h01, 9'h100, 5, acc, acc_cyc);
    applyStimulus(8'hFF, 8'hFF, 9'h1FE, 5, acc, acc_cyc);
    waitPops(3, 10);

    // Back-pressure: only FIFO_DEPTH pairs fit
    out_ready = 1'b0;
    acc_total = 0;
    for (int i = 1; i <= 6; i++) begin
      applyStimulus(8'(i), 8'(i), 9'(2 * i), 1, acc, acc_cyc);
      acc_total += int'(acc);
    end
    checkOutput("bp_accepted", 32'(acc_total), 32'd4);
    repeat (2) @(posedge clock);
    #1;
    checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
    checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    checkOutput("in_ready_after_pop", 32'(in_ready), 32'd1);
    applyStimulus(8'd5, 8'd5, 9'd10, 20, acc, acc_cyc);
    applyStimulus(8'd6, 8'd6, 9'd12, 20, acc, acc_cyc);
    waitPops(9, 30);
    checkOutput("bp_txn_count", 32'(txn_count), 32'd9);

    // Back-to-back streaming
    doReset();
    acc_total = 0;
    first_cyc = 0;
    for (int k = 0; k < 100; k++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      applyStimulus(ra, rb, 9'({1'b0, ra} + {1'b0, rb}), 1, acc, acc_cyc);
      acc_total += int'(acc);
      if (k == 0) first_cyc = acc_cyc;
    end
    waitPops(100, 50);
    checkOutput("stream_accepted", 32'(acc_total), 32'd100);
    checkOutput("stream_rate", 32'(last_pop_cyc - first_cyc), 32'd102);
    checkOutput("stream_txn_count", 32'(txn_count), 32'd100);
    checkOutput("stream_txn_w", 32'(txn_count_w), 32'd4);

    // Reset with three results buffered
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(8'(8'h10 + k), 8'h01, 9'(9'h011 + k), 5, acc, acc_cyc);
    end
    repeat (4) @(posedge clock);
    #1;
    checkOutput("pre_rst_out_valid", 32'(out_valid), 32'd1);
    checkOutput("pre_rst_in_ready", 32'(in_ready), 32'd1);
    reset = 1'b1;
    in_valid = 1'b1; in_a = 8'h55; in_b = 8'h55;
    #1;
    checkOutput("mid_rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("mid_rst_txn_count", 32'(txn_count), 32'd0);
    checkOutput("mid_rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("mid_rst_out_sum", 32'(out_sum), 32'd0);
    exp_q.delete();
    pop_count = 0;
    repeat (2) @(posedge clock);
    #1;
    in_valid = 1'b0;
    reset = 1'b0;
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    applyStimulus(8'h01, 8'h02, 9'h003, 5, acc, acc_cyc);
    waitPops(1, 10);
    repeat (6) @(posedge clock);
    #1;
    checkOutput("post_rst_pops", 32'(pop_count), 32'd1);
    checkOutput("post_rst_idle", 32'(out_valid), 32'd0);

    // Counter wrap on the 4-bit twin: 17 pops since reset
    for (int k = 0; k < 16; k++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      applyStimulus(ra, rb, 9'({1'b0, ra} + {1'b0, rb}), 5, acc, acc_cyc);
    end
    waitPops(17, 40);
    checkOutput("wrap_txn_main", 32'(txn_count), 32'd17);
    checkOutput("wrap_txn_w", 32'(txn_count_w), 32'd1);
    checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
